// File: rtl/jam_cost_table.sv
// ---------------------------------------------------------------------------
// jam_cost_table
//
// Cost-table front end for the JAM job-assignment engine.  A worker x job
// cost matrix is streamed in row-major order over a valid/ready handshake
// and held in a register array at address worker*N+job.  JAM reads it back
// through a registered W/J address with one cycle of latency.  While the
// matrix loads, the minimum of every row is tracked.  After the last entry
// the row minima are summed into LowerBound, which serves as a pruning
// bound.
//
// Ports
//   CLK          clock, rising edge
//   RST_n        asynchronous active-low reset
//   load_start   one-cycle pulse: clear load state and (re)start a load
//   in_valid     load stream valid
//   in_data      cost entry (COST_W bits), row-major order
//   in_ready     high while the block is accepting load data
//   table_ready  table complete and LowerBound valid
//   W, J         lookup worker / job index
//   Cost         table entry at the W/J captured on the previous edge
//   LowerBound   sum of the N row minima
// ---------------------------------------------------------------------------
module jam_cost_table #(
  parameter int COST_W = 7,
  parameter int N      = 8
) (
  input  logic                 CLK,
  input  logic                 RST_n,
  input  logic                 load_start,
  input  logic                 in_valid,
  input  logic [COST_W-1:0]    in_data,
  output logic                 in_ready,
  output logic                 table_ready,
  input  logic [$clog2(N)-1:0] W,
  input  logic [$clog2(N)-1:0] J,
  output logic [COST_W-1:0]    Cost,
  output logic [9:0]           LowerBound
);

  localparam int RW    = $clog2(N);
  localparam int AW    = 2 * RW;
  localparam int DEPTH = N * N;

  localparam logic [COST_W-1:0] MAX_COST = '1;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SUM,
    READY
  } state_t;

  state_t            r_state;
  state_t            w_next_state;

  logic [COST_W-1:0] r_mem     [DEPTH];
  logic [COST_W-1:0] r_row_min [N];
  logic [AW-1:0]     r_wptr;
  logic [9:0]        r_lower_bound;
  logic [RW-1:0]     r_wq;
  logic [RW-1:0]     r_jq;

  logic              w_accept;
  logic              w_last;
  logic [RW-1:0]     w_row;
  logic [9:0]        w_sum;

  // load_start takes priority over a coincident accept, so the word that
  // arrives with the restart pulse is dropped and the next one lands at 0.
  assign w_accept = (r_state == LOAD) && in_valid && !load_start;
  assign w_last   = (r_wptr == {AW{1'b1}});
  assign w_row    = r_wptr[AW-1:RW];

  // Status outputs come straight from the state register.
  assign in_ready    = (r_state == LOAD);
  assign table_ready = (r_state == READY);
  assign LowerBound  = r_lower_bound;

  // The table is only presented once it is complete; otherwise Cost is 0.
  assign Cost = table_ready ? r_mem[{r_wq, r_jq}] : '0;

  // Sum of the row minima, latched into LowerBound in the SUM state.
  always_comb begin
    w_sum = '0;
    for (int i = 0; i < N; i++) begin
      w_sum = w_sum + 10'(r_row_min[i]);
    end
  end

  // Next-state logic.  A load_start pulse restarts the load from any state,
  // including abandoning a SUM that has not yet completed.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    w_next_state = IDLE;
      LOAD:    if (w_accept && w_last) w_next_state = SUM;
      SUM:     w_next_state = READY;
      READY:   w_next_state = READY;
      default: w_next_state = IDLE;
    endcase
    if (load_start) begin
      w_next_state = LOAD;
    end
  end

  // State, write pointer, row minima, lower bound and lookup address.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      r_state       <= IDLE;
      r_wptr        <= '0;
      r_lower_bound <= '0;
      r_wq          <= '0;
      r_jq          <= '0;
      for (int i = 0; i < N; i++) begin
        r_row_min[i] <= MAX_COST;
      end
    end else begin
      r_state <= w_next_state;
      r_wq    <= W;
      r_jq    <= J;
      if (load_start) begin
        r_wptr        <= '0;
        r_lower_bound <= '0;
        for (int i = 0; i < N; i++) begin
          r_row_min[i] <= MAX_COST;
        end
      end else begin
        if (w_accept) begin
          r_wptr <= r_wptr + 1'b1;
          if (in_data < r_row_min[w_row]) begin
            r_row_min[w_row] <= in_data;
          end
        end
        if (r_state == SUM) begin
          r_lower_bound <= w_sum;
        end
      end
    end
  end

  // Cost storage.  It is not cleared by load_start because every entry is
  // rewritten during a load.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_accept) begin
      r_mem[r_wptr] <= in_data;
    end
  end

endmodule

// File: doc/jam_cost_table.md
# jam_cost_table

Cost-table front end for the JAM job-assignment engine. Loads the 8×8 worker/job cost matrix (7-bit entries) over a valid/ready stream and stores it row-major at address worker*8+job. Serves JAM's W/J lookups with the one-cycle registered-address timing JAM expects. Also precomputes the sum of per-worker minimum costs as a pruning lower bound.

## Interface
Parameters:
- COST_W, 7, cost entry width
- N, 8, workers = jobs; table depth N*N = 64

Ports:
- CLK  in  1  clock; all state updates on the rising edge
- RST_n  in  1  asynchronous, active-low reset
- load_start  in  1  one-cycle pulse; clears the table state and begins a load
- in_valid  in  1  load stream data valid
- in_data  in  7  cost entry, row-major order: w0j0..w0j7, w1j0, ..., w7j7
- in_ready  out  1  block accepts in_data this cycle
- table_ready  out  1  table complete and LowerBound valid; JAM start qualifier
- W  in  3  lookup worker index, from JAM
- J  in  3  lookup job index, from JAM
- Cost  out  7  table[8*W_q+J_q]; W_q/J_q are W/J registered at the previous edge
- LowerBound  out  10  sum of the 8 row minima (maximum 8*127 = 1016)

## Operation
- Storage: mem[0:63] of 7-bit entries; write pointer wptr[5:0]; row_min[0:7] of 7 bits; row index = wptr[5:3].
- FSM states: IDLE, LOAD, SUM, READY.
  - Reset: state IDLE, all mem = 0, all row_min = 127, wptr = 0, LowerBound = 0, W_q = J_q = 0.
  - IDLE: in_ready = 0. On load_start, go to LOAD.
  - LOAD: in_ready = 1. An accept occurs when in_valid && in_ready. On accept:
    - mem[wptr] <= in_data
    - row_min[wptr[5:3]] <= min(row_min[wptr[5:3]], in_data)
    - wptr++
    - If the accept is at wptr = 63, go to SUM. wptr wraps to 0.
  - SUM: in_ready = 0. LowerBound <= sum of row_min[0..7], zero-extended to 10 bits. Go to READY.
  - READY: table_ready = 1, in_ready = 0. On load_start, go to LOAD.
- load_start side effects (any state):
  - wptr <= 0, all row_min <= 127, LowerBound <= 0.
  - table_ready drops the next cycle.
  - mem is not cleared; every entry is overwritten during the load.
- Simultaneous load_start and accept: load_start wins. The data is discarded, and the next accept writes address 0.
- load_start in SUM: restarts the load (go to LOAD); SUM does not complete.
- Lookup path: W_q <= W and J_q <= J on every edge, in all states.
  - Cost = table_ready ? mem[{W_q, J_q}] : 0 (combinational from registers).
- Out-of-order or short loads are not detected. In LOAD, deasserting in_valid simply stalls.
- Arithmetic: row_min compare is unsigned 7-bit. The 10-bit sum cannot overflow.

## Timing
- Lookup latency:
  - W/J presented in cycle t are captured at edge t.
  - Cost is valid during cycle t+1, after clock-to-q plus mem mux delay.
  - Full throughput: one new lookup every cycle.
- Load throughput: one entry per cycle while in_valid = 1. The minimum load is 64 cycles of accepts.
- Completion:
  - The 64th accept at edge k moves the FSM to SUM.
  - At edge k+1, LowerBound is latched and table_ready rises.
  - table_ready is high from cycle k+1 (after edge k+1) onward.
- Reset values of outputs: in_ready = 0, table_ready = 0, Cost = 0, LowerBound = 0.
- Asynchronous reset mid-load aborts immediately to IDLE. A new load_start is then required.
- table_ready, in_ready and LowerBound are driven from registered state only, with no combinational path from inputs.
- Cost depends only on registers.

## Test plan
- Load entry value = (w*8+j) mod 128, with in_valid held high → exactly 64 accepts. table_ready rises 1 cycle after the last accept, LowerBound = 0+8+16+...+56 = 224, and Cost for W=5, J=3 (next cycle) = 43.
- Load a matrix with all entries 127 except mem[8*w+w] = w+1 → LowerBound = 36. Sweep all 64 W/J pairs back-to-back: each Cost equals the table entry one cycle after the address is presented.
- Toggle in_valid every other cycle during a load → still 64 writes, no extra or dropped entries. table_ready is timed from the last accept.
- After 30 accepts, pulse load_start coincident with an accept carrying 99, then load the matrix of all 5s → entry 0 = 5, LowerBound = 40, table_ready only after 64 new accepts.
- Drop RST_n for half a cycle at accept 50 → in_ready, table_ready, Cost and LowerBound are all 0 immediately. in_ready stays 0 until load_start, after which the load completes correctly.
- In READY with LowerBound = 224, pulse load_start → table_ready = 0 and Cost = 0 from the next cycle. Reload all 127s → LowerBound = 1016.
